// File: rtl/stage_buff_pkg.sv
// rtl/stage_buff_pkg.sv - shared state encoding and default widths for the stage buffers
package stage_buff_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } buff_state_e;

  localparam int WB_SIZE_DEF = 2;
  localparam int DATA_W_DEF  = 32;
  localparam int ALU_W_DEF   = 16;
  localparam int REG_W_DEF   = 3;
  localparam int SP_W_DEF    = 32;
  localparam int EPC_W_DEF   = 2;
  localparam int STALL_W_DEF = 8;

endpackage

// File: rtl/buff_payload_reg.sv
// rtl/buff_payload_reg.sv - payload register with load enable and async active-low clear
module buff_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign data_d = load_i ? d_i : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_wb_skid_buff.sv
// rtl/mem_wb_skid_buff.sv - MEM/WB stage buffer with valid/ready handshake, 2-entry skid,
// flush-to-bubble, writeback-control gating and a saturating stall counter.
module mem_wb_skid_buff
  import stage_buff_pkg::*;
#(
  parameter int WbSize   = WB_SIZE_DEF,
  parameter int DataW    = DATA_W_DEF,
  parameter int AluW     = ALU_W_DEF,
  parameter int RegW     = REG_W_DEF,
  parameter int SpW      = SP_W_DEF,
  parameter int EpcW     = EPC_W_DEF,
  parameter int NEG_EDGE = 1,
  parameter int StallW   = STALL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WbSize-1:0] i_WB,
  input  logic [DataW-1:0]  i_MemData,
  input  logic [AluW-1:0]   i_alu,
  input  logic [RegW-1:0]   i_Rdst,
  input  logic [SpW-1:0]    i_SP,
  input  logic [EpcW-1:0]   i_changeEPC,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WbSize-1:0] o_WB,
  output logic [DataW-1:0]  o_MemData,
  output logic [AluW-1:0]   o_alu,
  output logic [RegW-1:0]   o_Rdst,
  output logic [SpW-1:0]    o_SP,
  output logic [EpcW-1:0]   o_changeEPC,
  output logic [StallW-1:0] o_stall_cnt
);

  localparam int PayW = WbSize + DataW + AluW + RegW + SpW + EpcW;

  // A single derived clock keeps every flop on the same selectable capture edge.
  logic cap_clk;
  assign cap_clk = (NEG_EDGE != 0) ? ~clk : clk;

  buff_state_e state_q, state_d;
  logic [PayW-1:0] in_pay, main_pay, skid_pay, main_nxt;
  logic push, pop, main_ld, skid_ld, main_from_skid;
  logic [StallW-1:0] stall_q, stall_d;
  logic [WbSize-1:0] wb_held;
  logic [EpcW-1:0] epc_held;

  assign in_pay  = {i_WB, i_MemData, i_alu, i_Rdst, i_SP, i_changeEPC};
  assign o_valid = (state_q != EMPTY);
  assign o_ready = (state_q != SKID);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge cap_clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = FULL;
            main_ld = 1'b1;
          end
        end
        FULL: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_d = SKID;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (pop) begin
            state_d        = FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_nxt = main_from_skid ? skid_pay : in_pay;

  buff_payload_reg #(.W(PayW)) u_main (
    .clk    (cap_clk),
    .rst_n  (rst),
    .load_i (main_ld),
    .d_i    (main_nxt),
    .q_o    (main_pay)
  );

  buff_payload_reg #(.W(PayW)) u_skid (
    .clk    (cap_clk),
    .rst_n  (rst),
    .load_i (skid_ld),
    .d_i    (in_pay),
    .q_o    (skid_pay)
  );

  assign {wb_held, o_MemData, o_alu, o_Rdst, o_SP, epc_held} = main_pay;

  // Bubbles must never write the register file or the EPC.
  assign o_WB        = o_valid ? wb_held : '0;
  assign o_changeEPC = o_valid ? epc_held : '0;

  always_comb begin
    stall_d = stall_q;
    if (o_valid && !i_ready && !i_flush && (stall_q != {StallW{1'b1}})) begin
      stall_d = stall_q + {{(StallW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge cap_clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_buff.sv
// tb/tb_mem_wb_skid_buff.sv - bench for mem_wb_skid_buff, falling- and rising-edge instances
module tb_mem_wb_skid_buff;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] mem;
    logic [15:0] alu;
    logic [2:0]  rdst;
    logic [31:0] sp;
    logic [1:0]  epc;
  } pay_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [1:0]  wb;
    logic [31:0] mem;
    logic [15:0] alu;
    logic [2:0]  rdst;
    logic [31:0] sp;
    logic [1:0]  epc;
    logic [7:0]  stall;
  } out_t;

  typedef struct {
    logic        fl;
    logic        v;
    logic        r;
    logic [1:0]  wb;
    logic [31:0] mem;
    logic [2:0]  rdst;
    logic        ev;
    logic        er;
    logic [1:0]  ewb;
    logic [31:0] emem;
    logic [2:0]  erdst;
    logic [1:0]  estall;
  } vec_t;

  logic clk, rst, i_flush, i_valid, i_ready;
  logic [1:0]  i_WB, i_changeEPC;
  logic [31:0] i_MemData, i_SP;
  logic [15:0] i_alu;
  logic [2:0]  i_Rdst;

  logic        a_valid, a_ready, b_valid, b_ready;
  logic [1:0]  a_wb, a_epc, b_wb, b_epc;
  logic [31:0] a_mem, a_sp, b_mem, b_sp;
  logic [15:0] a_alu, b_alu;
  logic [2:0]  a_rdst, b_rdst;
  logic [1:0]  a_stall;
  logic [7:0]  b_stall;
  out_t a_o, b_o;

  int n_cmp = 0;
  int n_bad = 0;

  pay_t mq[$];
  pay_t last_head;
  int   stall_cnt;

  mem_wb_skid_buff #(.NEG_EDGE(1), .StallW(2)) u_dut_neg (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(a_ready),
    .i_WB(i_WB), .i_MemData(i_MemData), .i_alu(i_alu), .i_Rdst(i_Rdst), .i_SP(i_SP),
    .i_changeEPC(i_changeEPC), .o_valid(a_valid), .i_ready(i_ready), .o_WB(a_wb),
    .o_MemData(a_mem), .o_alu(a_alu), .o_Rdst(a_rdst), .o_SP(a_sp),
    .o_changeEPC(a_epc), .o_stall_cnt(a_stall)
  );

  mem_wb_skid_buff #(.NEG_EDGE(0), .StallW(8)) u_dut_pos (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(b_ready),
    .i_WB(i_WB), .i_MemData(i_MemData), .i_alu(i_alu), .i_Rdst(i_Rdst), .i_SP(i_SP),
    .i_changeEPC(i_changeEPC), .o_valid(b_valid), .i_ready(i_ready), .o_WB(b_wb),
    .o_MemData(b_mem), .o_alu(b_alu), .o_Rdst(b_rdst), .o_SP(b_sp),
    .o_changeEPC(b_epc), .o_stall_cnt(b_stall)
  );

  assign a_o = {a_valid, a_ready, a_wb, a_mem, a_alu, a_rdst, a_sp, a_epc, 6'd0, a_stall};
  assign b_o = {b_valid, b_ready, b_wb, b_mem, b_alu, b_rdst, b_sp, b_epc, b_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input out_t act, input out_t exp);
    cmp({tag, ".valid"}, 64'(act.valid), 64'(exp.valid));
    cmp({tag, ".ready"}, 64'(act.ready), 64'(exp.ready));
    cmp({tag, ".wb"},    64'(act.wb),    64'(exp.wb));
    cmp({tag, ".mem"},   64'(act.mem),   64'(exp.mem));
    cmp({tag, ".alu"},   64'(act.alu),   64'(exp.alu));
    cmp({tag, ".rdst"},  64'(act.rdst),  64'(exp.rdst));
    cmp({tag, ".sp"},    64'(act.sp),    64'(exp.sp));
    cmp({tag, ".epc"},   64'(act.epc),   64'(exp.epc));
    cmp({tag, ".stall"}, 64'(act.stall), 64'(exp.stall));
  endtask

  // Reference: an ordered queue of at most two entries; the head shown is the last one that led it.
  function automatic out_t model_out(input int sat);
    out_t o;
    o.valid = (mq.size() != 0);
    o.ready = (mq.size() < 2);
    o.wb    = o.valid ? last_head.wb : 2'd0;
    o.mem   = last_head.mem;
    o.alu   = last_head.alu;
    o.rdst  = last_head.rdst;
    o.sp    = last_head.sp;
    o.epc   = o.valid ? last_head.epc : 2'd0;
    o.stall = 8'((stall_cnt > sat) ? sat : stall_cnt);
    return o;
  endfunction

  task automatic model_step(input logic fl, input logic v, input logic r, input pay_t p);
    bit push, pop;
    push = v && (mq.size() < 2);
    pop  = (mq.size() != 0) && r;
    if ((mq.size() != 0) && !r && !fl) stall_cnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(p);
    end
    if (mq.size() != 0) last_head = mq[0];
  endtask

  task automatic model_reset();
    mq.delete();
    last_head = '0;
    stall_cnt = 0;
  endtask

  // Entered and left at t = 7 (mod 10): falling capture at +3, rising capture at +8.
  task automatic step(input logic fl, input logic v, input logic r, input pay_t p);
    out_t prev_b, nxt_a, nxt_b;
    prev_b = model_out(255);
    model_step(fl, v, r, p);
    nxt_a = model_out(3);
    nxt_b = model_out(255);
    i_flush = fl; i_valid = v; i_ready = r;
    i_WB = p.wb; i_MemData = p.mem; i_alu = p.alu; i_Rdst = p.rdst; i_SP = p.sp; i_changeEPC = p.epc;
    #4;
    chk_out("neg_after_fall", a_o, nxt_a);
    chk_out("pos_before_rise", b_o, prev_b);
    #5;
    chk_out("pos_after_rise", b_o, nxt_b);
    chk_out("neg_hold_rise", a_o, nxt_a);
    #1;
  endtask

  task automatic do_reset();
    model_reset();
    rst = 1'b0;
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    #1;
    chk_out("rst_neg", a_o, model_out(3));
    chk_out("rst_pos", b_o, model_out(255));
    #9;
    rst = 1'b1;
  endtask

  function automatic pay_t mkpay(input logic [1:0] wb, input logic [31:0] mem, input logic [2:0] rdst);
    pay_t p;
    p.wb = wb; p.mem = mem; p.alu = mem[15:0]; p.rdst = rdst; p.sp = ~mem; p.epc = wb;
    return p;
  endfunction

  vec_t vt[12];
  int   sat_exp[6];

  initial begin
    rst = 1'b0;
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_WB = '0; i_MemData = '0; i_alu = '0; i_Rdst = '0; i_SP = '0; i_changeEPC = '0;
    #7;
    do_reset();

    //          fl    v     r     wb    mem            rdst  ev    er    ewb   emem           erdst estall
    vt[0]  = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h11111111, 3'd3, 1'b1, 1'b1, 2'd1, 32'h11111111, 3'd3, 2'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h22222222, 3'd5, 1'b1, 1'b1, 2'd2, 32'h22222222, 3'd5, 2'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        3'd0, 1'b0, 1'b1, 2'd0, 32'h22222222, 3'd5, 2'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h33333333, 3'd1, 1'b1, 1'b1, 2'd3, 32'h33333333, 3'd1, 2'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h44444444, 3'd2, 1'b1, 1'b0, 2'd3, 32'h33333333, 3'd1, 2'd1};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h55555555, 3'd7, 1'b1, 1'b0, 2'd3, 32'h33333333, 3'd1, 2'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        3'd0, 1'b1, 1'b1, 2'd1, 32'h44444444, 3'd2, 2'd2};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h66666666, 3'd6, 1'b1, 1'b0, 2'd1, 32'h44444444, 3'd2, 2'd3};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h77777777, 3'd7, 1'b0, 1'b1, 2'd0, 32'h44444444, 3'd2, 2'd3};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        3'd0, 1'b0, 1'b1, 2'd0, 32'h44444444, 3'd2, 2'd3};
    vt[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h88888888, 3'd0, 1'b0, 1'b1, 2'd0, 32'h44444444, 3'd2, 2'd3};
    vt[11] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h99999999, 3'd4, 1'b1, 1'b1, 2'd2, 32'h99999999, 3'd4, 2'd3};

    for (int i = 0; i < 12; i++) begin
      step(vt[i].fl, vt[i].v, vt[i].r, mkpay(vt[i].wb, vt[i].mem, vt[i].rdst));
      cmp($sformatf("vec%0d.valid", i), 64'(a_valid), 64'(vt[i].ev));
      cmp($sformatf("vec%0d.ready", i), 64'(a_ready), 64'(vt[i].er));
      cmp($sformatf("vec%0d.wb", i),    64'(a_wb),    64'(vt[i].ewb));
      cmp($sformatf("vec%0d.epc", i),   64'(a_epc),   64'(vt[i].ewb));
      cmp($sformatf("vec%0d.mem", i),   64'(a_mem),   64'(vt[i].emem));
      cmp($sformatf("vec%0d.rdst", i),  64'(a_rdst),  64'(vt[i].erdst));
      cmp($sformatf("vec%0d.stall", i), 64'(a_stall), 64'(vt[i].estall));
    end

    // Stall saturation on the 2-bit counter from a fresh reset.
    do_reset();
    step(1'b0, 1'b1, 1'b0, mkpay(2'd1, 32'hABCD0001, 3'd1));
    sat_exp = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, mkpay(2'd0, 32'h0, 3'd0));
      cmp($sformatf("sat%0d.neg", i), 64'(a_stall), 64'(sat_exp[i]));
      cmp($sformatf("sat%0d.pos", i), 64'(b_stall), 64'(i + 1));
    end

    // Reset asserted while two entries are held.
    step(1'b0, 1'b1, 1'b0, mkpay(2'd2, 32'hCAFE0002, 3'd2));
    cmp("pre_rst.ready", 64'(a_ready), 64'(0));
    do_reset();
    cmp("midrst.valid", 64'(a_valid), 64'(0));
    step(1'b0, 1'b0, 1'b1, mkpay(2'd0, 32'h0, 3'd0));
    cmp("post_rst.valid", 64'(a_valid), 64'(0));

    for (int i = 0; i < 400; i++) begin
      pay_t p;
      p.wb = 2'($urandom); p.mem = $urandom; p.alu = 16'($urandom);
      p.rdst = 3'($urandom); p.sp = $urandom; p.epc = 2'($urandom);
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 6), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_buff.md
Name: mem_wb_skid_buff

Overview:
- Parametrised successor of the MEM/WB pipeline register.
- Adds a valid/ready handshake, a 2-entry skid so upstream ready is registered, and a flush that inserts a bubble.
- Adds bubble gating of writeback controls, a selectable capture edge and a saturating stall counter.
- Sits between the memory stage and writeback; also reusable for any stage boundary carrying the same payload.

Parameters:
- WbSize, 2, width of writeback control field
- DataW, 32, memory data width
- AluW, 16, ALU result width
- RegW, 3, destination register index width
- SpW, 32, stack pointer width
- EpcW, 2, change-EPC control width
- NEG_EDGE, 1, 1 = capture on falling clk edge (stage-buffer convention), 0 = rising edge
- StallW, 8, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_flush  in  1  kill all held entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  buffer can accept (registered)
- i_WB  in  WbSize  writeback controls
- i_MemData  in  DataW  memory read data
- i_alu  in  AluW  ALU result
- i_Rdst  in  RegW  destination register
- i_SP  in  SpW  stack pointer
- i_changeEPC  in  EpcW  EPC update control
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head
- o_WB, o_MemData, o_alu, o_Rdst, o_SP, o_changeEPC  out  matching widths  head entry payload
- o_stall_cnt  out  StallW  cycles spent with o_valid=1 and i_ready=0

Behaviour:
- Capture edge: all state updates on negedge clk if NEG_EDGE=1, else posedge. Reset is independent of either edge.
- Reset (rst=0, asynchronous): state=EMPTY, o_valid=0, o_ready=1, all payload outputs 0, o_stall_cnt=0, skid payload 0.
- push = i_valid & o_ready; pop = o_valid & i_ready. Both are evaluated at the capture edge.
- States: EMPTY (o_valid=0, o_ready=1), FULL (main held, o_valid=1, o_ready=1), SKID (main and skid held, o_valid=1, o_ready=0).
- EMPTY: push -> FULL, main<=in. No push -> stay.
- FULL:
  - push & pop -> FULL, main<=in.
  - push & !pop -> SKID, skid<=in.
  - !push & pop -> EMPTY.
  - Otherwise hold.
- SKID: pop -> FULL, main<=skid. No pop -> hold. Push is impossible because o_ready=0; i_valid is ignored.
- Latency: an accepted entry is visible on the outputs after one capture edge from EMPTY or FULL+pop. Throughput is 1 entry per edge while i_ready=1.
- Ordering: strict FIFO; skid content never overtakes main.
- Flush: highest priority over push and pop. Next state=EMPTY, o_valid=0, o_ready=1. A same-edge push is dropped. Payload registers hold their value except o_WB and o_changeEPC.
- Bubble gating: whenever o_valid=0, o_WB and o_changeEPC read 0, so no register or EPC write can occur. The other payload outputs hold their last value.
- Stall counter: +1 per capture edge with o_valid & !i_ready & !i_flush. Saturates at 2^StallW-1 with no wrap. Cleared only by reset.
- Reset mid-operation (any state) immediately forces the reset values. The first capture edge after rst rises behaves as EMPTY.

Decomposition:
- Shared package stage_buff_pkg holds the state enum {EMPTY, FULL, SKID} and the default width constants. These are shared with the other stage buffers.
- One natural sub-module: buff_payload_reg, a parametrised payload register with load enable and async active-low clear. It is instantiated twice (main, skid).
- The FSM, handshake and counter stay in the top module.

Test Plan:
- Reset mid-SKID, rst=0 -> o_valid=0, o_ready=1, o_WB=0, o_MemData=0, o_stall_cnt=0 immediately, without waiting for a clock edge.
- Streaming with i_ready=1, entries A(MemData=0x11111111, Rdst=3), B(0x22222222, Rdst=5) on consecutive edges -> outputs show A then B one edge later each; o_ready stays 1.
- Backpressure: A accepted, then i_ready=0 while B arrives -> SKID, o_ready=0, o_alu keeps A. After i_ready=1 -> A popped, B shown, o_ready=1, order A,B preserved.
- Flush in SKID with i_valid=1 (entry C) -> EMPTY, o_valid=0, o_WB=0, o_changeEPC=0. C never appears on the outputs.
- Stall saturation, StallW=2: hold o_valid=1, i_ready=0 for 6 edges -> o_stall_cnt 1,2,3,3,3,3.
- NEG_EDGE=0 vs 1: the same stimulus captures on the rising vs falling edge respectively; outputs are unchanged on the opposite edge.
